uart_mmio_bridge: RTL

- Processor-side end of the UART byte-stream interface. Turns core load/store accesses into AXI-stream traffic toward the UART core, and turns the UART's receive stream back into core-readable bytes.
- Contains a TX FIFO and an RX FIFO, a status/control register pair, and an interrupt line.
- Sits between the rv32 core's peripheral bus and the uart instance. Single clock domain; any clock crossing to the serial clock is handled outside this block.

---
 rtl/uart_mmio_bridge.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped bridge between a core bus and a UART byte stream: TX/RX byte FIFOs, status/control, level irq.
// Bus reads return one cycle later; TX holds its head until tx_tready, RX is always ready and drops on overrun.

module uart_mmio_bridge_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    head_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Storage is never reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module uart_mmio_bridge #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic        irq
);
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic [7:0]    rx_head;

  logic        rx_irq_en_q, tx_irq_en_q;
  logic        rx_ovr_q, rx_ovr_d;
  logic        tx_drop_q, tx_drop_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        rx_tready_q;

  logic        wr_acc, rd_acc, ctrl_wr;
  logic        tx_full, tx_push_req, tx_push, tx_pop;
  logic        rx_full, rx_in, rx_push, rx_pop, rx_flush;
  logic [31:0] status, rd_val;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  // A simultaneous write and read is treated as a write only.
  assign wr_acc  = sel & we;
  assign rd_acc  = sel & re & ~we;
  assign ctrl_wr = wr_acc & (addr == 4'h8);

  assign tx_full     = (tx_count == CW'(DEPTH));
  assign tx_pop      = tx_tvalid & tx_tready;
  assign tx_push_req = wr_acc & (addr == 4'h0);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_pop   = rd_acc & (addr == 4'h0) & (rx_count != '0);
  assign rx_flush = ctrl_wr & wdata[3];
  assign rx_in    = rx_tvalid & rx_tready_q;
  assign rx_push  = rx_in & ~rx_flush & (~rx_full | rx_pop);

  uart_mmio_bridge_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .flush_i (1'b0),
    .din_i   (wdata[7:0]),
    .head_o  (tx_tdata),
    .count_o (tx_count)
  );

  uart_mmio_bridge_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .din_i   (rx_tdata),
    .head_o  (rx_head),
    .count_o (rx_count)
  );

  always_comb begin
    status          = '0;
    status[0]       = (rx_count != '0);
    status[1]       = tx_full;
    status[2]       = (tx_count == '0);
    status[3]       = rx_ovr_q;
    status[4]       = tx_drop_q;
    status[8 +: CW] = rx_count;
    status[16 +: CW] = tx_count;

    case (addr)
      4'h0:    rd_val = (rx_count == '0) ? 32'h8000_0000 : {24'h0, rx_head};
      4'h4:    rd_val = status;
      4'h8:    rd_val = {30'h0, tx_irq_en_q, rx_irq_en_q};
      default: rd_val = '0;
    endcase

    rdata_d = rd_acc ? rd_val : '0;
    irq_d   = (rx_irq_en_q & (rx_count != '0)) | (tx_irq_en_q & (tx_count == '0));

    // A new drop/overrun in the same cycle as the clearing write survives it.
    tx_drop_d = (tx_drop_q & ~(ctrl_wr & wdata[2])) | (tx_push_req & tx_full & ~tx_pop);
    rx_ovr_d  = (rx_ovr_q & ~(ctrl_wr & wdata[2])) | (rx_in & ~rx_flush & rx_full & ~rx_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_drop_q   <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      rx_tready_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_irq_en_q <= wdata[0];
        tx_irq_en_q <= wdata[1];
      end
      rx_ovr_q    <= rx_ovr_d;
      tx_drop_q   <= tx_drop_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      rx_tready_q <= 1'b1;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = irq_q;
  assign rx_tready = rx_tready_q;
  assign tx_tvalid = (tx_count != '0);
endmodule
